// File: rtl/mix_block_out_if.sv
// Command, memory-port and UART-line bundle for the MIX block-output unit.
// master is the output unit itself; slave is the CPU/memory/line side.
interface mix_block_out_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WORD_W = 30
);
    logic              start;
    logic [ADDR_W-1:0] addressin;
    logic              stop;
    logic              busy;
    logic              request;
    logic [ADDR_W-1:0] addressout;
    logic              load;
    logic [WORD_W-1:0] in;
    logic              tx;

    modport master (
        input  start, addressin, load, in,
        output stop, busy, request, addressout, tx
    );

    modport slave (
        output start, addressin, load, in,
        input  stop, busy, request, addressout, tx
    );
endinterface

// File: rtl/mix_block_out.sv
// MIX block-output unit: fetches BLOCK_WORDS words from memory and sends their
// bytes MSB-first as 8N1 UART frames, optionally followed by CR/LF.
module mix_block_out #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BYTES       = 5,
    parameter int unsigned BYTE_BITS   = 6,
    parameter int unsigned BLOCK_WORDS = 14,
    parameter int unsigned CLK_DIV     = 217,
    parameter int unsigned EOL         = 1
) (
    input  logic            clk,
    input  logic            reset,
    mix_block_out_if.master bus
);

    localparam int unsigned WORD_W = BYTES * BYTE_BITS;
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(BLOCK_WORDS - 1);
    localparam logic [3:0]        STOP_BIT  = 4'd9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_EOLS  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W-1:0] base_q,       base_d;
    logic [WIDX_W-1:0] widx_q,       widx_d;
    logic [WORD_W-1:0] word_q,       word_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [3:0]        bit_q,        bit_d;
    logic [BYTE_W-1:0] byte_q,       byte_d;
    logic              eol_q,        eol_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic              stop_q,       stop_d;
    logic              busy_q,       busy_d;
    logic              request_q,    request_d;
    logic [ADDR_W-1:0] addressout_q, addressout_d;
    logic              tx_q,         tx_d;

    logic              launch_c;
    logic [ADDR_W-1:0] launch_addr_c;
    logic [7:0]        char_c;

    // Line value of frame bit idx: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] ch, input logic [3:0] idx);
        if (idx == 4'd0) begin
            return 1'b0;
        end else if (idx <= 4'd8) begin
            return ch[3'(idx - 4'd1)];
        end else begin
            return 1'b1;
        end
    endfunction

    // Character on the line: top byte of the shifting word, or CR/LF.
    always_comb begin
        char_c = 8'(word_q[WORD_W-1 -: BYTE_BITS]);
        if (state_q == ST_EOLS) begin
            char_c = eol_q ? 8'h0A : 8'h0D;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        widx_d        = widx_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        eol_d         = eol_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        stop_d        = 1'b0;
        request_d     = request_q;
        addressout_d  = addressout_q;
        tx_d          = tx_q;
        launch_c      = 1'b0;
        launch_addr_c = bus.addressin;

        // A command arriving mid-block waits in the single pending slot; latest wins.
        if (bus.start && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.addressin;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (bus.start) begin
                    launch_c = 1'b1;
                end
            end

            ST_FETCH: begin
                if (request_q && bus.load) begin
                    word_d    = bus.in;
                    request_d = 1'b0;
                    state_d   = ST_SEND;
                    byte_d    = '0;
                    bit_d     = '0;
                    cnt_d     = '0;
                    tx_d      = 1'b0;
                end
            end

            ST_SEND, ST_EOLS: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q != STOP_BIT) begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = frame_bit(char_c, bit_q + 4'd1);
                    end else if ((state_q == ST_SEND) && (byte_q != BYTE_LAST)) begin
                        byte_d = byte_q + BYTE_W'(1);
                        word_d = word_q << BYTE_BITS;
                        bit_d  = '0;
                        tx_d   = 1'b0;
                    end else if ((state_q == ST_SEND) && (widx_q != WIDX_LAST)) begin
                        widx_d       = widx_q + WIDX_W'(1);
                        addressout_d = base_q + ADDR_W'(widx_q + WIDX_W'(1));
                        request_d    = 1'b1;
                        state_d      = ST_FETCH;
                        tx_d         = 1'b1;
                    end else if ((state_q == ST_SEND) && (EOL != 0)) begin
                        state_d = ST_EOLS;
                        eol_d   = 1'b0;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                    end else if ((state_q == ST_EOLS) && !eol_q) begin
                        eol_d = 1'b1;
                        bit_d = '0;
                        tx_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        tx_d    = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                tx_d = 1'b1;
                if (bus.start || pend_valid_q) begin
                    launch_c      = 1'b1;
                    launch_addr_c = bus.start ? bus.addressin : pend_addr_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                request_d = 1'b0;
                tx_d      = 1'b1;
            end
        endcase

        // Accepting a block: acknowledge with stop and request the first word at once.
        if (launch_c) begin
            state_d      = ST_FETCH;
            base_d       = launch_addr_c;
            widx_d       = '0;
            pend_valid_d = 1'b0;
            stop_d       = 1'b1;
            request_d    = 1'b1;
            addressout_d = launch_addr_c;
            tx_d         = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            widx_q       <= '0;
            word_q       <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            eol_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            request_q    <= 1'b0;
            addressout_q <= '0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            widx_q       <= widx_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            eol_q        <= eol_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
            request_q    <= request_d;
            addressout_q <= addressout_d;
            tx_q         <= tx_d;
        end
    end

    assign bus.stop       = stop_q;
    assign bus.busy       = busy_q;
    assign bus.request    = request_q;
    assign bus.addressout = addressout_q;
    assign bus.tx         = tx_q;

endmodule

// File: tb/tb_mix_block_out.sv
// Randomised bench for mix_block_out: memory responder with random grant delay,
// UART line decoder, and a queue-based model of the frames each block must produce.
module tb_mix_block_out;

    localparam int ADDR_W      = 12;
    localparam int BYTES       = 5;
    localparam int BYTE_BITS   = 6;
    localparam int BLOCK_WORDS = 2;
    localparam int CLK_DIV     = 4;
    localparam int EOL         = 1;
    localparam int WORD_W      = BYTES * BYTE_BITS;
    localparam int FRAMES      = BLOCK_WORDS * BYTES + 2 * EOL;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mix_block_out_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    mix_block_out #(
        .ADDR_W(ADDR_W), .BYTES(BYTES), .BYTE_BITS(BYTE_BITS),
        .BLOCK_WORDS(BLOCK_WORDS), .CLK_DIV(CLK_DIV), .EOL(EOL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] mem [1 << ADDR_W];
    int exp_chars[$];
    int exp_addr[$];
    int n_checks = 0;
    int n_pass   = 0;
    int stop_cnt = 0;
    int exp_stops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected memory addresses and line characters for a block at base m.
    task automatic push_block(input int m);
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            int a;
            a = (m + w) % (1 << ADDR_W);
            exp_addr.push_back(a);
            for (int b = 0; b < BYTES; b++)
                exp_chars.push_back(int'((mem[a] >> ((BYTES - 1 - b) * BYTE_BITS)) & 63));
        end
        if (EOL != 0) begin
            exp_chars.push_back(13);
            exp_chars.push_back(10);
        end
    endtask

    task automatic issue(input int m);
        bus.start     = 1'b1;
        bus.addressin = ADDR_W'(m);
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'h0);
        check({tag, "_drained"}, 32'(exp_chars.size() + exp_addr.size()), 32'h0);
    endtask

    // Memory port: grants after 0..3 cycles, and throws in stray loads while idle.
    initial begin : responder
        int wait_left;
        int expect_a;
        wait_left = -1;
        expect_a  = 0;
        bus.load  = 1'b0;
        bus.in    = '0;
        forever begin
            @(negedge clk);
            bus.load = 1'b0;
            if (reset || !bus.request) begin
                wait_left = -1;
                if (!reset && $urandom_range(0, 7) == 0) begin
                    bus.load = 1'b1;
                    bus.in   = WORD_W'($urandom);
                end
            end else begin
                if (wait_left < 0) begin
                    wait_left = $urandom_range(0, 3);
                    expect_a  = (exp_addr.size() > 0) ? exp_addr.pop_front() : -1;
                    check("fetch_addr", 32'(bus.addressout), 32'(expect_a));
                end else begin
                    check("addr_stable", 32'(bus.addressout), 32'(expect_a));
                end
                check("tx_idle_fetch", 32'(bus.tx), 32'h1);
                if (wait_left == 0) begin
                    bus.load = 1'b1;
                    bus.in   = mem[bus.addressout];
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Line decoder: every bit must hold for exactly CLK_DIV samples.
    int mon_cnt;
    bit mon_act = 1'b0;
    bit mon_bad;
    logic [9:0] mon_bits;
    always @(negedge clk) begin
        if (reset) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (bus.tx == 1'b0) begin
                mon_act  = 1'b1;
                mon_cnt  = 1;
                mon_bits = '0;
                mon_bad  = 1'b0;
            end
        end else begin
            int k;
            k = mon_cnt / CLK_DIV;
            if (mon_cnt % CLK_DIV == 0) mon_bits[k] = bus.tx;
            else if (bus.tx !== mon_bits[k]) mon_bad = 1'b1;
            mon_cnt++;
            if (mon_cnt == 10 * CLK_DIV) begin
                mon_act = 1'b0;
                if (exp_chars.size() == 0) begin
                    check("frame_unexpected", 32'(mon_bits[8:1]), 32'h100);
                end else begin
                    check("frame_char", 32'(mon_bits[8:1]), 32'(exp_chars.pop_front()));
                    check("frame_shape", 32'({mon_bad, mon_bits[9]}), 32'h1);
                end
            end
        end
    end

    always @(negedge clk) if (!reset && bus.stop) stop_cnt++;

    initial begin : main
        int n;
        bit dropped;
        bus.start     = 1'b0;
        bus.addressin = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = WORD_W'($urandom);
        mem[100] = 30'h01083105;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'h1);
        check("rst_stop", 32'(bus.stop), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_request", 32'(bus.request), 32'h0);
        check("rst_addressout", 32'(bus.addressout), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Known word at M=100: bytes 01..05.
        push_block(100);
        check("model_byte0", 32'(exp_chars[0]), 32'h1);
        exp_stops++;
        issue(100);
        check("t1_stop", 32'(bus.stop), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'h1);
        check("t1_request", 32'(bus.request), 32'h1);
        @(negedge clk);
        check("t1_stop_pulse", 32'(bus.stop), 32'h0);
        wait_idle("t1");

        // Address wrap at the top of memory.
        push_block(4095);
        exp_stops++;
        issue(4095);
        check("wrap_stop", 32'(bus.stop), 32'h1);
        wait_idle("wrap");

        // Pending command, overwritten once, launched back to back.
        push_block(300);
        exp_stops++;
        issue(300);
        repeat (50) @(negedge clk);
        issue(500);
        check("pend_no_stop1", 32'(bus.stop), 32'h0);
        repeat (100) @(negedge clk);
        issue(200);
        check("pend_no_stop2", 32'(bus.stop), 32'h0);
        push_block(200);
        exp_stops++;
        n = 0;
        dropped = 1'b0;
        while (!bus.stop && n < 3000) begin
            if (!bus.busy) dropped = 1'b1;
            @(negedge clk);
            n++;
        end
        check("pend_stop_seen", 32'(bus.stop), 32'h1);
        check("pend_busy_held", 32'(dropped), 32'h0);
        check("pend_block1_done", 32'(exp_chars.size()), 32'(FRAMES));
        if (!bus.request) @(negedge clk);
        check("pend_request", 32'(bus.request), 32'h1);
        check("pend_addr", 32'(bus.addressout), 32'd200);
        wait_idle("pend");

        // Random blocks.
        for (int r = 0; r < 5; r++) begin
            int m;
            m = $urandom_range(0, (1 << ADDR_W) - 1);
            repeat ($urandom_range(1, 6)) @(negedge clk);
            push_block(m);
            exp_stops++;
            issue(m);
            check("rnd_stop", 32'(bus.stop), 32'h1);
            wait_idle("rnd");
        end

        // Reset in the middle of a data bit.
        push_block(77);
        exp_stops++;
        issue(77);
        n = 0;
        while (bus.tx && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_txlow", 32'(bus.tx), 32'h0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(bus.tx), 32'h1);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_request", 32'(bus.request), 32'h0);
        check("rst_mid_stop", 32'(bus.stop), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_chars.delete();
        exp_addr.delete();
        @(negedge clk);
        push_block(100);
        exp_stops++;
        issue(100);
        check("post_rst_stop", 32'(bus.stop), 32'h1);
        wait_idle("post_rst");

        check("stop_count", 32'(stop_cnt), 32'(exp_stops));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
